// File: rtl/elevator_motion_ctrl_pkg.sv
// Shared elevator encodings (state, travel mode, one-hot floors) and one-hot floor helpers.
// Used by the motion controller and by the request processor.
package elev_pkg;

    typedef enum logic [2:0] {
        ST_STOP  = 3'b000,
        ST_PAUSE = 3'b001,
        ST_MOVE  = 3'b010
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10
    } mode_t;

    localparam logic [3:0] FLOOR1 = 4'b0001;
    localparam logic [3:0] FLOOR2 = 4'b0010;
    localparam logic [3:0] FLOOR3 = 4'b0100;
    localparam logic [3:0] FLOOR4 = 4'b1000;

    function automatic logic [3:0] step_floor(input logic [3:0] pos, input mode_t mode);
        return (mode == MODE_UP) ? {pos[2:0], 1'b0} : {1'b0, pos[3:1]};
    endfunction

    // True when the cabin cannot travel any further in the given direction.
    function automatic logic at_end(input logic [3:0] pos, input mode_t mode);
        return ((mode == MODE_UP) && (pos == FLOOR4)) ||
               ((mode == MODE_DOWN) && (pos == FLOOR1));
    endfunction

endpackage

// File: rtl/elevator_motion_ctrl_if.sv
// Link between the request processor and the motion controller.
// master = motion controller, slave = request processor.
interface elevator_motion_ctrl_if;
    logic       up_need;
    logic       down_need;
    logic [3:0] allReq_reg;
    logic [3:0] position;
    logic [1:0] ud_mode;
    logic [2:0] state;
    logic       door_open;
    logic [1:0] floor_idx;

    modport master (
        input  up_need, down_need, allReq_reg,
        output position, ud_mode, state, door_open, floor_idx
    );

    modport slave (
        output up_need, down_need, allReq_reg,
        input  position, ud_mode, state, door_open, floor_idx
    );
endinterface

// File: rtl/elevator_motion_ctrl_tick_timer.sv
// 8-bit loadable down-counter; load wins over counting, stops at zero.
// done is high for the single cycle the count sits at 1.
module elev_tick_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd1);
endmodule

// File: rtl/elevator_motion_ctrl.sv
// STOP/MOVE/PAUSE sequencer for a 4-floor cabin; all outputs registered, decisions land one clk later.
// One shared tick timer times both floor travel and door dwell.
module elevator_motion_ctrl
    import elev_pkg::*;
#(
    parameter int MOVE_TICKS  = 64,
    parameter int PAUSE_TICKS = 96
) (
    input  logic                  clk,
    input  logic                  rst,
    elevator_motion_ctrl_if.master bus
);
    localparam logic [7:0] MOVE_LD  = 8'(MOVE_TICKS);
    localparam logic [7:0] PAUSE_LD = 8'(PAUSE_TICKS);

    state_t     state_q, state_d;
    mode_t      mode_q, mode_d;
    logic [3:0] pos_q, pos_d, next_pos;
    logic [1:0] idx_q, idx_d;
    logic       door_q;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_done;
    logic       here_req, next_req, same_need;

    elev_tick_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pos_d     = pos_q;
        idx_d     = idx_q;
        tmr_load  = 1'b0;
        tmr_val   = MOVE_LD;
        next_pos  = step_floor(pos_q, mode_q);
        here_req  = |(bus.allReq_reg & pos_q);
        next_req  = |(bus.allReq_reg & next_pos);
        same_need = (mode_q == MODE_UP) ? bus.up_need : bus.down_need;

        case (state_q)
            ST_STOP: begin
                mode_d = MODE_IDLE;
                if (here_req) begin
                    state_d  = ST_PAUSE;
                    tmr_load = 1'b1;
                    tmr_val  = PAUSE_LD;
                end else if (bus.up_need) begin
                    state_d  = ST_MOVE;
                    mode_d   = MODE_UP;
                    tmr_load = 1'b1;
                end else if (bus.down_need) begin
                    state_d  = ST_MOVE;
                    mode_d   = MODE_DOWN;
                    tmr_load = 1'b1;
                end
            end

            ST_MOVE: begin
                if (tmr_done) begin
                    // Entered at the end floor in this direction: give up without shifting.
                    if (at_end(pos_q, mode_q)) begin
                        state_d = ST_STOP;
                        mode_d  = MODE_IDLE;
                    end else begin
                        pos_d = next_pos;
                        idx_d = (mode_q == MODE_UP) ? idx_q + 2'd1 : idx_q - 2'd1;
                        if (next_req) begin
                            state_d  = ST_PAUSE;
                            tmr_load = 1'b1;
                            tmr_val  = PAUSE_LD;
                        end else if (same_need && !at_end(next_pos, mode_q)) begin
                            tmr_load = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                            mode_d  = MODE_IDLE;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (here_req) begin
                    tmr_load = 1'b1;
                    tmr_val  = PAUSE_LD;
                end else if (tmr_done) begin
                    // Keep the current travel direction before reconsidering the other one.
                    if ((mode_q == MODE_UP) && bus.up_need) begin
                        state_d  = ST_MOVE;
                        tmr_load = 1'b1;
                    end else if ((mode_q == MODE_DOWN) && bus.down_need) begin
                        state_d  = ST_MOVE;
                        tmr_load = 1'b1;
                    end else if (bus.up_need) begin
                        state_d  = ST_MOVE;
                        mode_d   = MODE_UP;
                        tmr_load = 1'b1;
                    end else if (bus.down_need) begin
                        state_d  = ST_MOVE;
                        mode_d   = MODE_DOWN;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_STOP;
                        mode_d  = MODE_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_STOP;
                mode_d  = MODE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            mode_q  <= MODE_IDLE;
            pos_q   <= FLOOR1;
            idx_q   <= 2'd0;
            door_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            door_q  <= (state_d == ST_PAUSE);
        end
    end

    assign bus.position  = pos_q;
    assign bus.ud_mode   = mode_q;
    assign bus.state     = state_q;
    assign bus.door_open = door_q;
    assign bus.floor_idx = idx_q;
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed scenarios plus random stimulus, checked every cycle against a floor/direction-level model.
module tb_elevator_motion_ctrl;
    localparam int MT = 4;
    localparam int PT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   checking = 1'b0;

    elevator_motion_ctrl_if bus();

    elevator_motion_ctrl #(.MOVE_TICKS(MT), .PAUSE_TICKS(PT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Model: floor number, direction (0 none, 1 up, 2 down), phase (0 stop, 1 door open, 2 travelling)
    // and how many cycles remain in the current travel leg or door dwell.
    int m_floor, m_dir, m_st, m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_floor = 0; m_dir = 0; m_st = 0; m_left = 0;
        end else begin
            case (m_st)
                0: begin
                    m_dir = 0;
                    if (bus.allReq_reg[m_floor]) begin m_st = 1; m_left = PT; end
                    else if (bus.up_need)        begin m_st = 2; m_dir = 1; m_left = MT; end
                    else if (bus.down_need)      begin m_st = 2; m_dir = 2; m_left = MT; end
                end
                2: begin
                    if (m_left > 1) m_left--;
                    else if ((m_dir == 1 && m_floor == 3) || (m_dir == 2 && m_floor == 0)) begin
                        m_st = 0; m_dir = 0;
                    end else begin
                        m_floor += (m_dir == 1) ? 1 : -1;
                        if (bus.allReq_reg[m_floor]) begin m_st = 1; m_left = PT; end
                        else if (m_dir == 1 ? (bus.up_need && m_floor < 3)
                                            : (bus.down_need && m_floor > 0)) m_left = MT;
                        else begin m_st = 0; m_dir = 0; end
                    end
                end
                default: begin
                    if (bus.allReq_reg[m_floor]) m_left = PT;
                    else if (m_left > 1) m_left--;
                    else if (m_dir == 1 && bus.up_need)   begin m_st = 2; m_left = MT; end
                    else if (m_dir == 2 && bus.down_need) begin m_st = 2; m_left = MT; end
                    else if (bus.up_need)   begin m_st = 2; m_dir = 1; m_left = MT; end
                    else if (bus.down_need) begin m_st = 2; m_dir = 2; m_left = MT; end
                    else begin m_st = 0; m_dir = 0; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking && !rst) begin
            chk("state",     32'(bus.state),     32'(m_st));
            chk("position",  32'(bus.position),  32'(1 << m_floor));
            chk("floor_idx", 32'(bus.floor_idx), 32'(m_floor));
            chk("ud_mode",   32'(bus.ud_mode),   32'(m_dir));
            chk("door_open", 32'(bus.door_open), 32'(m_st == 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic up, input logic dn, input logic [3:0] req);
        bus.up_need    = up;
        bus.down_need  = dn;
        bus.allReq_reg = req;
    endtask

    task automatic chk_out(string tag, logic [2:0] st, logic [3:0] pos, logic [1:0] ud, logic door);
        chk({tag, "_state"},    32'(bus.state),     32'(st));
        chk({tag, "_position"}, 32'(bus.position),  32'(pos));
        chk({tag, "_ud_mode"},  32'(bus.ud_mode),   32'(ud));
        chk({tag, "_door"},     32'(bus.door_open), 32'(door));
    endtask

    initial begin
        int open_cnt;
        set_in(1'b0, 1'b0, 4'b0000);
        tick(3);
        chk_out("reset", 3'b000, 4'b0001, 2'b00, 1'b0);
        chk("reset_floor_idx", 32'(bus.floor_idx), 32'd0);
        rst = 1'b0;
        checking = 1'b1;

        tick(20);
        chk_out("idle20", 3'b000, 4'b0001, 2'b00, 1'b0);

        // Floor 1 -> 3 with up_need, serve floor 3.
        set_in(1'b1, 1'b0, 4'b0100);
        tick(1);
        chk_out("go_up", 3'b010, 4'b0001, 2'b01, 1'b0);
        tick(4);
        chk_out("at_f2", 3'b010, 4'b0010, 2'b01, 1'b0);
        tick(4);
        chk_out("at_f3", 3'b001, 4'b0100, 2'b01, 1'b1);
        set_in(1'b0, 1'b0, 4'b0000);
        tick(5);
        chk("f3_door_last", 32'(bus.door_open), 32'd1);
        tick(1);
        chk_out("f3_stop", 3'b000, 4'b0100, 2'b00, 1'b0);

        // Door hold at floor 3: request held across 10 door-open edges.
        bus.allReq_reg = 4'b0100;
        open_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (bus.door_open) open_cnt++;
            if (i == 10) bus.allReq_reg = 4'b0000;
        end
        chk("hold_open_cycles", 32'(open_cnt), 32'd16);

        // Stale up_need carried to the top floor.
        set_in(1'b1, 1'b0, 4'b0000);
        tick(5);
        chk_out("f4_arrive", 3'b000, 4'b1000, 2'b00, 1'b0);
        tick(1);
        chk_out("f4_stale", 3'b010, 4'b1000, 2'b01, 1'b0);
        tick(4);
        chk_out("f4_noshift", 3'b000, 4'b1000, 2'b00, 1'b0);
        set_in(1'b0, 1'b0, 4'b0000);

        // Down to floor 2, then both needs: direction is kept.
        set_in(1'b0, 1'b1, 4'b0010);
        tick(9);
        chk_out("f2_pause", 3'b001, 4'b0010, 2'b10, 1'b1);
        set_in(1'b1, 1'b1, 4'b0000);
        tick(6);
        chk_out("f2_keepdir", 3'b010, 4'b0010, 2'b10, 1'b0);

        // Asynchronous reset mid-travel with two cycles of the leg left.
        tick(2);
        chk("pre_rst_position", 32'(bus.position), 32'b0010);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 3'b000, 4'b0001, 2'b00, 1'b0);
        chk("async_rst_idx", 32'(bus.floor_idx), 32'd0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            tick(1);
            bus.up_need    = ($urandom_range(0, 2) == 0);
            bus.down_need  = ($urandom_range(0, 2) == 0);
            bus.allReq_reg = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
